// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, forwarding and data-memory wait controller
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic             Branch_D,
    input  logic             Branch_Taken_D,
    input  logic [4:0]       Rs_E,
    input  logic [4:0]       Rt_E,
    input  logic [4:0]       Write_Reg_E,
    input  logic             Reg_Write_E,
    input  logic             MemToReg_E,
    input  logic [4:0]       Write_Reg_M,
    input  logic             Reg_Write_M,
    input  logic             MemToReg_M,
    input  logic             Mem_Req_M,
    input  logic             Mem_Ready,
    input  logic [4:0]       Write_Reg_W,
    input  logic             Reg_Write_W,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Bubble_W,
    output logic [1:0]       Forward_A_E,
    output logic [1:0]       Forward_B_E,
    output logic             Forward_A_D,
    output logic             Forward_B_D,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Stall_Cycles
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic mem_hold, load_use, branch_haz, at_limit;

    function automatic logic reg_match(input logic [4:0] x, input logic [4:0] r);
        return (r != 5'd0) && (x == r);
    endfunction

    assign at_limit = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        mem_hold   = (state_q == RUN) ? (Mem_Req_M && !Mem_Ready) : (!Mem_Ready && !at_limit);
        load_use   = MemToReg_E && (reg_match(Rs_D, Write_Reg_E) || reg_match(Rt_D, Write_Reg_E));
        branch_haz = Branch_D &&
                     ((Reg_Write_E && (reg_match(Rs_D, Write_Reg_E) || reg_match(Rt_D, Write_Reg_E))) ||
                      (MemToReg_M  && (reg_match(Rs_D, Write_Reg_M) || reg_match(Rt_D, Write_Reg_M))));
    end

    // Pipeline controls; memory hold dominates, then ID-stage hazards, then taken branch.
    always_comb begin
        Stall_F  = 1'b0;
        Stall_D  = 1'b0;
        Stall_E  = 1'b0;
        Stall_M  = 1'b0;
        Flush_D  = 1'b0;
        Flush_E  = 1'b0;
        Bubble_W = 1'b0;
        if (rst) begin
            Flush_E  = 1'b1;
            Bubble_W = 1'b1;
        end else if (mem_hold) begin
            Stall_F  = 1'b1;
            Stall_D  = 1'b1;
            Stall_E  = 1'b1;
            Stall_M  = 1'b1;
            Bubble_W = 1'b1;
        end else if (load_use || branch_haz) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end else begin
            Flush_D = Branch_Taken_D;
        end
    end

    always_comb begin
        Forward_A_E = 2'b00;
        Forward_B_E = 2'b00;
        Forward_A_D = 1'b0;
        Forward_B_D = 1'b0;
        if (!rst) begin
            if (Reg_Write_M && reg_match(Rs_E, Write_Reg_M))      Forward_A_E = 2'b10;
            else if (Reg_Write_W && reg_match(Rs_E, Write_Reg_W)) Forward_A_E = 2'b01;
            if (Reg_Write_M && reg_match(Rt_E, Write_Reg_M))      Forward_B_E = 2'b10;
            else if (Reg_Write_W && reg_match(Rt_E, Write_Reg_W)) Forward_B_E = 2'b01;
            Forward_A_D = Reg_Write_M && reg_match(Rs_D, Write_Reg_M);
            Forward_B_D = Reg_Write_M && reg_match(Rt_D, Write_Reg_M);
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_hold) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (Mem_Ready || at_limit) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (!Mem_Ready) mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (Stall_F && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Mem_Err      = mem_err_q;
    assign Stall_Cycles = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, Write_Reg_E, Write_Reg_M, Write_Reg_W;
    logic Branch_D, Branch_Taken_D, Reg_Write_E, MemToReg_E, Reg_Write_M, MemToReg_M;
    logic Mem_Req_M, Mem_Ready, Reg_Write_W;
    logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W;
    logic [1:0] Forward_A_E, Forward_B_E;
    logic Forward_A_D, Forward_B_D, Mem_Err;
    logic [CW-1:0] Stall_Cycles;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Branch_D(Branch_D), .Branch_Taken_D(Branch_Taken_D),
        .Rs_E(Rs_E), .Rt_E(Rt_E), .Write_Reg_E(Write_Reg_E), .Reg_Write_E(Reg_Write_E),
        .MemToReg_E(MemToReg_E), .Write_Reg_M(Write_Reg_M), .Reg_Write_M(Reg_Write_M),
        .MemToReg_M(MemToReg_M), .Mem_Req_M(Mem_Req_M), .Mem_Ready(Mem_Ready),
        .Write_Reg_W(Write_Reg_W), .Reg_Write_W(Reg_Write_W),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Bubble_W(Bubble_W),
        .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
        .Forward_A_D(Forward_A_D), .Forward_B_D(Forward_B_D),
        .Mem_Err(Mem_Err), .Stall_Cycles(Stall_Cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state: whether an access is being waited on and how many cycles it has stalled so far.
    bit         m_waiting;
    int         m_waited;
    bit         m_err;
    int         m_cycles;
    bit         e_hold;
    logic [6:0] e_ctl;
    logic [5:0] e_fwd;

    function automatic bit mt(input logic [4:0] x, input logic [4:0] r);
        return (r != 0) && (x == r);
    endfunction

    function automatic logic [6:0] ctl_obs();
        return {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W};
    endfunction

    task automatic model_outputs();
        bit lu, bh;
        logic [1:0] fa, fb;
        e_hold = 1'b0;
        if (rst) begin
            e_ctl = 7'b0000011;
            e_fwd = 6'b0;
            return;
        end
        e_hold = !Mem_Ready && (m_waiting ? (m_waited < T) : Mem_Req_M);
        lu = MemToReg_E && (mt(Rs_D, Write_Reg_E) || mt(Rt_D, Write_Reg_E));
        bh = Branch_D && ((Reg_Write_E && (mt(Rs_D, Write_Reg_E) || mt(Rt_D, Write_Reg_E))) ||
                          (MemToReg_M && (mt(Rs_D, Write_Reg_M) || mt(Rt_D, Write_Reg_M))));
        if (e_hold)        e_ctl = 7'b1111001;
        else if (lu || bh) e_ctl = 7'b1100010;
        else               e_ctl = {4'b0000, Branch_Taken_D, 2'b00};
        fa = (Reg_Write_M && mt(Rs_E, Write_Reg_M)) ? 2'd2 : (Reg_Write_W && mt(Rs_E, Write_Reg_W)) ? 2'd1 : 2'd0;
        fb = (Reg_Write_M && mt(Rt_E, Write_Reg_M)) ? 2'd2 : (Reg_Write_W && mt(Rt_E, Write_Reg_W)) ? 2'd1 : 2'd0;
        e_fwd = {fa, fb, Reg_Write_M && mt(Rs_D, Write_Reg_M), Reg_Write_M && mt(Rt_D, Write_Reg_M)};
    endtask

    // Called just after a falling edge with inputs applied; ends at the next falling edge.
    task automatic cycle();
        if (rst) begin
            m_waiting = 0; m_waited = 0; m_err = 0; m_cycles = 0;
        end
        #1;
        model_outputs();
        check("ctl", 32'(ctl_obs()), 32'(e_ctl));
        check("fwd", 32'({Forward_A_E, Forward_B_E, Forward_A_D, Forward_B_D}), 32'(e_fwd));
        check("mem_err", 32'(Mem_Err), 32'(m_err));
        check("stall_cycles", 32'(Stall_Cycles), 32'(m_cycles));
        @(posedge clk);
        if (!rst) begin
            if (e_ctl[6] && m_cycles < CMAX) m_cycles++;
            if (e_hold) begin
                m_waiting = 1; m_waited++;
            end else begin
                if (m_waiting && !Mem_Ready) m_err = 1;
                m_waiting = 0; m_waited = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        {Rs_D, Rt_D, Rs_E, Rt_E, Write_Reg_E, Write_Reg_M, Write_Reg_W} = '0;
        {Branch_D, Branch_Taken_D, Reg_Write_E, MemToReg_E, Reg_Write_M, MemToReg_M} = '0;
        {Mem_Req_M, Mem_Ready, Reg_Write_W} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        @(negedge clk);
        cycle();
        check("rst_flush_e", 32'(Flush_E), 32'd1);
        check("rst_bubble_w", 32'(Bubble_W), 32'd1);
        rst = 1'b0;

        // Forwarding priority: MEM beats WB.
        Reg_Write_M = 1; Write_Reg_M = 5; Rs_E = 5; Reg_Write_W = 1; Write_Reg_W = 5; Rt_E = 5;
        #1;
        check("fwd_a_mem", 32'(Forward_A_E), 32'd2);
        check("fwd_b_mem", 32'(Forward_B_E), 32'd2);
        cycle();
        Write_Reg_M = 0; Rs_E = 0;
        #1;
        check("fwd_a_r0", 32'(Forward_A_E), 32'd0);
        check("fwd_b_wb", 32'(Forward_B_E), 32'd1);
        cycle();

        idle();
        MemToReg_E = 1; Write_Reg_E = 8; Rt_D = 8;
        #1;
        check("lu_ctl", 32'(ctl_obs()), 32'h62);
        cycle();
        idle();
        #1;
        check("lu_count", 32'(Stall_Cycles), 32'd1);

        Branch_D = 1; Reg_Write_E = 1; Write_Reg_E = 3; Rs_D = 3;
        #1;
        check("br_stall", 32'(ctl_obs()), 32'h62);
        cycle();
        idle();
        Branch_D = 1; Branch_Taken_D = 1;
        #1;
        check("br_flush_d", 32'(ctl_obs()), 32'h04);
        cycle();

        // Access ready after three wait cycles.
        do_reset();
        Mem_Req_M = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_hold", 32'({Stall_M, Bubble_W, Flush_E}), 32'b110);
            cycle();
        end
        Mem_Ready = 1;
        #1;
        check("mw_release", 32'(Stall_M), 32'd0);
        cycle();
        idle();
        #1;
        check("mw_count", 32'(Stall_Cycles), 32'd3);

        // Never ready: timeout and sticky error, then reset in the middle of a second wait.
        Mem_Req_M = 1;
        for (int i = 0; i < T; i++) begin
            #1;
            check("to_hold", 32'(Stall_F), 32'd1);
            cycle();
        end
        #1;
        check("to_release", 32'(Stall_F), 32'd0);
        check("to_err_pre", 32'(Mem_Err), 32'd0);
        cycle();
        #1;
        check("to_err", 32'(Mem_Err), 32'd1);
        cycle();
        check("to_rewait", 32'(Stall_F), 32'd1);
        cycle();
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(Stall_F), 32'd0);
        check("rst_mid_err", 32'(Mem_Err), 32'd0);
        cycle();
        rst = 1'b0;

        // Counter saturation.
        idle();
        MemToReg_E = 1; Write_Reg_E = 8; Rs_D = 8;
        for (int i = 0; i < 20; i++) cycle();
        #1;
        check("sat", 32'(Stall_Cycles), 32'd15);
        idle();
        cycle();

        for (int i = 0; i < 1500; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            Rs_D           = 5'($urandom_range(0, 3));
            Rt_D           = 5'($urandom_range(0, 3));
            Rs_E           = 5'($urandom_range(0, 3));
            Rt_E           = 5'($urandom_range(0, 3));
            Write_Reg_E    = 5'($urandom_range(0, 3));
            Write_Reg_M    = 5'($urandom_range(0, 3));
            Write_Reg_W    = 5'($urandom_range(0, 3));
            Branch_D       = 1'($urandom);
            Branch_Taken_D = 1'($urandom);
            Reg_Write_E    = 1'($urandom);
            MemToReg_E     = ($urandom_range(0, 3) == 0);
            Reg_Write_M    = 1'($urandom);
            MemToReg_M     = 1'($urandom);
            Reg_Write_W    = 1'($urandom);
            Mem_Req_M      = 1'($urandom);
            Mem_Ready      = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
